// File: rtl/pipe_hazard_ctrl.sv
// Central hazard and stall controller for the 5-stage pipeline.
// Produces decode-stage forwarding selects and detects load-use hazards.
// Sequences multi-cycle mul/div occupancy of execute and freezes the back
// end while data memory is not ready. All stall and forward outputs are
// combinational from state plus current inputs, so they add no latency.
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        duse_rs,
    input  logic        duse_rt,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mmem,
    input  logic [4:0]  mrn,
    input  logic        emdu,
    input  logic        dbranch_taken,
    input  logic        dmem_ready,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        wpcir,
    output logic        fflush,
    output logic        de_en,
    output logic        dbubble,
    output logic        em_bubble,
    output logic        pipe_freeze,
    output logic        mdu_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MDU   = 2'd1,
        MWAIT = 2'd2
    } state_t;

    // Counter value loaded on mul/div entry: the entry cycle is spent in RUN.
    localparam logic [3:0] MDU_START = 4'(MDU_LAT - 32'd1);
    // A single-cycle mul/div never needs the MDU state.
    localparam logic       MDU_MULTI = (MDU_LAT > 32'd1);

    state_t      state_r;
    state_t      state_next_s;
    state_t      eff_state_s;
    logic [3:0]  mdu_cnt_r;
    logic [3:0]  mdu_cnt_next_s;
    logic        ret_mdu_r;
    logic        ret_mdu_next_s;
    logic [15:0] stall_cnt_r;

    logic        lu_s;
    logic        mw_s;
    logic [1:0]  fwda_s;
    logic [1:0]  fwdb_s;
    logic        wpcir_s;
    logic        fflush_s;
    logic        de_en_s;
    logic        dbubble_s;
    logic        em_bubble_s;
    logic        pipe_freeze_s;
    logic        mdu_done_s;

    // Operand source select for one decode-stage register; E beats M.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       e_wr,
        input logic       e_ld,
        input logic [4:0] e_rn,
        input logic       m_wr,
        input logic       m_ld,
        input logic [4:0] m_rn
    );
        logic [1:0] sel;
        if (e_wr && !e_ld && (e_rn != 5'd0) && (e_rn == src)) begin
            sel = 2'b01;
        end else if (m_wr && !m_ld && (m_rn != 5'd0) && (m_rn == src)) begin
            sel = 2'b10;
        end else if (m_wr && m_ld && (m_rn != 5'd0) && (m_rn == src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign lu_s = ewreg && em2reg && (ern != 5'd0) &&
                  ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));
    assign mw_s = mmem && !dmem_ready;

    // Forwarding selects, forced to the register file while in reset.
    always_comb begin
        fwda_s = 2'b00;
        fwdb_s = 2'b00;
        if (resetn) begin
            fwda_s = fwd_sel(drs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
            fwdb_s = fwd_sel(drt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
        end else begin
            fwda_s = 2'b00;
            fwdb_s = 2'b00;
        end
    end

    // Stall, bubble, flush and freeze decisions plus FSM next state.
    always_comb begin
        wpcir_s        = 1'b1;
        de_en_s        = 1'b1;
        dbubble_s      = 1'b0;
        em_bubble_s    = 1'b0;
        fflush_s       = 1'b0;
        pipe_freeze_s  = 1'b0;
        mdu_done_s     = 1'b0;
        state_next_s   = RUN;
        mdu_cnt_next_s = mdu_cnt_r;
        ret_mdu_next_s = ret_mdu_r;

        // A released memory wait behaves exactly like the state it interrupted.
        if (state_r == MWAIT) begin
            eff_state_s = ret_mdu_r ? MDU : RUN;
        end else begin
            eff_state_s = state_r;
        end

        if (!resetn) begin
            wpcir_s        = 1'b0;
            de_en_s        = 1'b1;
            dbubble_s      = 1'b1;
            em_bubble_s    = 1'b1;
            fflush_s       = 1'b1;
            state_next_s   = RUN;
            mdu_cnt_next_s = 4'd0;
            ret_mdu_next_s = 1'b0;
        end else if (mw_s) begin
            // Whole pipe holds; the mul/div counter does not advance.
            wpcir_s       = 1'b0;
            de_en_s       = 1'b0;
            pipe_freeze_s = 1'b1;
            state_next_s  = MWAIT;
            if (state_r == MWAIT) begin
                ret_mdu_next_s = ret_mdu_r;
            end else begin
                ret_mdu_next_s = (state_r == MDU);
            end
        end else begin
            ret_mdu_next_s = 1'b0;
            case (eff_state_s)
                RUN: begin
                    if (emdu && MDU_MULTI) begin
                        wpcir_s        = 1'b0;
                        de_en_s        = 1'b0;
                        em_bubble_s    = 1'b1;
                        state_next_s   = MDU;
                        mdu_cnt_next_s = MDU_START;
                    end else if (lu_s) begin
                        // Branch is not flushed: it re-resolves next cycle.
                        wpcir_s      = 1'b0;
                        dbubble_s    = 1'b1;
                        state_next_s = RUN;
                    end else begin
                        fflush_s     = dbranch_taken;
                        state_next_s = RUN;
                    end
                end
                MDU: begin
                    if (mdu_cnt_r > 4'd1) begin
                        wpcir_s        = 1'b0;
                        de_en_s        = 1'b0;
                        em_bubble_s    = 1'b1;
                        state_next_s   = MDU;
                        mdu_cnt_next_s = mdu_cnt_r - 4'd1;
                    end else begin
                        mdu_done_s     = 1'b1;
                        state_next_s   = RUN;
                        mdu_cnt_next_s = 4'd0;
                        if (lu_s) begin
                            wpcir_s   = 1'b0;
                            dbubble_s = 1'b1;
                        end else begin
                            fflush_s  = dbranch_taken;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: insert a bubble and resync.
                    wpcir_s        = 1'b0;
                    dbubble_s      = 1'b1;
                    state_next_s   = RUN;
                    mdu_cnt_next_s = 4'd0;
                end
            endcase
        end
    end

    // State, mul/div counter, wait-return bit and saturating stall counter.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r     <= RUN;
            mdu_cnt_r   <= 4'd0;
            ret_mdu_r   <= 1'b0;
            stall_cnt_r <= 16'd0;
        end else begin
            state_r   <= state_next_s;
            mdu_cnt_r <= mdu_cnt_next_s;
            ret_mdu_r <= ret_mdu_next_s;
            if (!wpcir_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign fwda        = fwda_s;
    assign fwdb        = fwdb_s;
    assign wpcir       = wpcir_s;
    assign fflush      = fflush_s;
    assign de_en       = de_en_s;
    assign dbubble     = dbubble_s;
    assign em_bubble   = em_bubble_s;
    assign pipe_freeze = pipe_freeze_s;
    assign mdu_done    = mdu_done_s;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  drs, drt, ern, mrn;
    logic        duse_rs, duse_rt, ewreg, em2reg, mwreg, mm2reg, mmem;
    logic        emdu, dbranch_taken, dmem_ready;
    logic [1:0]  fwda, fwdb, fwda1, fwdb1;
    logic        wpcir, fflush, de_en, dbubble, em_bubble, pipe_freeze, mdu_done;
    logic        wpcir1, fflush1, de_en1, dbubble1, em_bubble1, pipe_freeze1, mdu_done1;
    logic [15:0] stall_cnt, stall_cnt1;
    logic [6:0]  ctl, ctl1;

    int checks   = 0;
    int failures = 0;

    // Control outputs packed as {wpcir,de_en,dbubble,em_bubble,fflush,pipe_freeze,mdu_done}
    assign ctl  = {wpcir, de_en, dbubble, em_bubble, fflush, pipe_freeze, mdu_done};
    assign ctl1 = {wpcir1, de_en1, dbubble1, em_bubble1, fflush1, pipe_freeze1, mdu_done1};

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MDU_LAT(LAT)) dut (
        .clock(clock), .resetn(resetn), .drs(drs), .drt(drt),
        .duse_rs(duse_rs), .duse_rt(duse_rt), .ewreg(ewreg), .em2reg(em2reg),
        .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mmem(mmem), .mrn(mrn),
        .emdu(emdu), .dbranch_taken(dbranch_taken), .dmem_ready(dmem_ready),
        .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .fflush(fflush), .de_en(de_en),
        .dbubble(dbubble), .em_bubble(em_bubble), .pipe_freeze(pipe_freeze),
        .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.MDU_LAT(1)) dut1 (
        .clock(clock), .resetn(resetn), .drs(drs), .drt(drt),
        .duse_rs(duse_rs), .duse_rt(duse_rt), .ewreg(ewreg), .em2reg(em2reg),
        .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mmem(mmem), .mrn(mrn),
        .emdu(emdu), .dbranch_taken(dbranch_taken), .dmem_ready(dmem_ready),
        .fwda(fwda1), .fwdb(fwdb1), .wpcir(wpcir1), .fflush(fflush1), .de_en(de_en1),
        .dbubble(dbubble1), .em_bubble(em_bubble1), .pipe_freeze(pipe_freeze1),
        .mdu_done(mdu_done1), .stall_cnt(stall_cnt1)
    );

    task automatic idle_inputs();
        resetn = 1'b1; drs = 5'd0; drt = 5'd0; duse_rs = 1'b0; duse_rt = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0; mwreg = 1'b0; mm2reg = 1'b0;
        mmem = 1'b0; mrn = 5'd0; emdu = 1'b0; dbranch_taken = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0; ewreg = 1'b1; ern = 5'd5; drs = 5'd5;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b0111100) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0111100); end
        checks++;
        if (fwda !== 2'b00) begin failures++; $display("FAIL reset_fwda got=%b exp=%b", fwda, 2'b00); end
        tick();
        @(negedge clock);
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        tick();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (ctl !== 7'b1100000) begin failures++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, 7'b1100000); end
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        ewreg = 1'b1; em2reg = 1'b0; ern = 5'd5;
        mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd5; mmem = 1'b1; dmem_ready = 1'b1;
        drs = 5'd5; drt = 5'd0;
        @(negedge clock);
        checks++;
        if (fwda !== 2'b01) begin failures++; $display("FAIL fwd_e_prio got=%b exp=%b", fwda, 2'b01); end
        checks++;
        if (fwdb !== 2'b00) begin failures++; $display("FAIL fwd_rt_r0 got=%b exp=%b", fwdb, 2'b00); end
        tick();
        ewreg = 1'b0;
        @(negedge clock);
        checks++;
        if (fwda !== 2'b11) begin failures++; $display("FAIL fwd_m_load got=%b exp=%b", fwda, 2'b11); end
        tick();
        drs = 5'd0;
        @(negedge clock);
        checks++;
        if (fwda !== 2'b00) begin failures++; $display("FAIL fwd_r0 got=%b exp=%b", fwda, 2'b00); end
        tick();
        mm2reg = 1'b0; mmem = 1'b0; drt = 5'd5;
        @(negedge clock);
        checks++;
        if (fwdb !== 2'b10) begin failures++; $display("FAIL fwd_m_alu got=%b exp=%b", fwdb, 2'b10); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; drs = 5'd1; drt = 5'd3; duse_rt = 1'b1;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b0110000) begin failures++; $display("FAIL lu_stall got=%b exp=%b", ctl, 7'b0110000); end
        tick();
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
        mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd3; mmem = 1'b1; dmem_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b1100000) begin failures++; $display("FAIL lu_release got=%b exp=%b", ctl, 7'b1100000); end
        checks++;
        if (fwdb !== 2'b11) begin failures++; $display("FAIL lu_fwdb got=%b exp=%b", fwdb, 2'b11); end
        checks++;
        if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        tick();
    endtask

    task automatic test_mdu();
        logic [6:0] exp;
        do_reset();
        emdu = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            exp = (i < LAT - 1) ? 7'b0001000 : 7'b1100001;
            @(negedge clock);
            checks++;
            if (ctl !== exp) begin failures++; $display("FAIL mdu_cycle%0d got=%b exp=%b", i, ctl, exp); end
            checks++;
            if (ctl1 !== 7'b1100000) begin failures++; $display("FAIL mdu_lat1_cycle%0d got=%b exp=%b", i, ctl1, 7'b1100000); end
            tick();
        end
        emdu = 1'b0;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b1100000) begin failures++; $display("FAIL mdu_after got=%b exp=%b", ctl, 7'b1100000); end
        checks++;
        if (stall_cnt !== 16'd3) begin failures++; $display("FAIL mdu_stall_cnt got=%0d exp=3", stall_cnt); end
        checks++;
        if (stall_cnt1 !== 16'd0) begin failures++; $display("FAIL mdu_lat1_stall_cnt got=%0d exp=0", stall_cnt1); end
        tick();
    endtask

    task automatic test_mdu_memwait();
        logic [6:0] exp_tab [6];
        logic       rdy_tab [6];
        exp_tab = '{7'b0001000, 7'b0000010, 7'b0000010, 7'b0001000, 7'b0001000, 7'b1100001};
        rdy_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        emdu = 1'b1; mmem = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_ready = rdy_tab[i];
            @(negedge clock);
            checks++;
            if (ctl !== exp_tab[i]) begin failures++; $display("FAIL mdu_wait_cycle%0d got=%b exp=%b", i, ctl, exp_tab[i]); end
            tick();
        end
        emdu = 1'b0; mmem = 1'b0;
        @(negedge clock);
        checks++;
        if (stall_cnt !== 16'd5) begin failures++; $display("FAIL mdu_wait_stall_cnt got=%0d exp=5", stall_cnt); end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        dbranch_taken = 1'b1;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b1100100) begin failures++; $display("FAIL br_flush got=%b exp=%b", ctl, 7'b1100100); end
        tick();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; drs = 5'd3; duse_rs = 1'b1;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b0110000) begin failures++; $display("FAIL br_lu got=%b exp=%b", ctl, 7'b0110000); end
        tick();
        ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b1100100) begin failures++; $display("FAIL br_retry got=%b exp=%b", ctl, 7'b1100100); end
        tick();
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        emdu = 1'b1;
        tick();
        resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (ctl !== 7'b0111100) begin failures++; $display("FAIL rst_mdu_ctl got=%b exp=%b", ctl, 7'b0111100); end
        tick();
        idle_inputs();
        @(negedge clock);
        checks++;
        if (ctl !== 7'b1100000) begin failures++; $display("FAIL rst_mdu_run got=%b exp=%b", ctl, 7'b1100000); end
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_mdu_stall got=%0d exp=0", stall_cnt); end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clock);
            checks++;
            if (mdu_done !== 1'b0) begin failures++; $display("FAIL rst_mdu_done%0d got=%b exp=0", i, mdu_done); end
        end
        tick();
    endtask

    // Reference forwarding rule taken straight from the operand-select table.
    function automatic logic [1:0] fwd_ref(input logic [4:0] r);
        if (ewreg && !em2reg && ern != 5'd0 && ern == r) return 2'b01;
        if (mwreg && !mm2reg && mrn != 5'd0 && mrn == r) return 2'b10;
        if (mwreg && mm2reg && mrn != 5'd0 && mrn == r) return 2'b11;
        return 2'b00;
    endfunction

    task automatic test_random();
        int         spent;
        int         exp_stall;
        logic [6:0] exp_ctl;
        logic [1:0] exp_a, exp_b;
        logic       mw, lu;
        do_reset();
        spent = 0;
        exp_stall = 0;
        for (int n = 0; n < 3000; n++) begin
            resetn        = ($urandom_range(0, 63) != 0);
            drs           = 5'($urandom_range(0, 3));
            drt           = 5'($urandom_range(0, 3));
            ern           = 5'($urandom_range(0, 3));
            mrn           = 5'($urandom_range(0, 3));
            duse_rs       = 1'($urandom_range(0, 1));
            duse_rt       = 1'($urandom_range(0, 1));
            ewreg         = 1'($urandom_range(0, 1));
            em2reg        = 1'($urandom_range(0, 1));
            mwreg         = 1'($urandom_range(0, 1));
            mm2reg        = 1'($urandom_range(0, 1));
            mmem          = ($urandom_range(0, 3) == 0);
            dmem_ready    = ($urandom_range(0, 3) != 0);
            emdu          = ($urandom_range(0, 7) == 0);
            dbranch_taken = 1'($urandom_range(0, 1));
            mw = mmem && !dmem_ready;
            lu = ewreg && em2reg && ern != 5'd0 &&
                 ((duse_rs && ern == drs) || (duse_rt && ern == drt));
            exp_a = resetn ? fwd_ref(drs) : 2'b00;
            exp_b = resetn ? fwd_ref(drt) : 2'b00;
            if (!resetn) begin
                exp_ctl = 7'b0111100;
            end else if (mw) begin
                exp_ctl = 7'b0000010;
            end else if (spent == 0 && emdu && LAT > 1) begin
                exp_ctl = 7'b0001000;
            end else if (spent == 0 || spent == LAT - 1) begin
                exp_ctl = lu ? 7'b0110000 : {4'b1100, dbranch_taken, 2'b00};
                exp_ctl[0] = (spent != 0);
            end else begin
                exp_ctl = 7'b0001000;
            end
            @(negedge clock);
            checks++;
            if (ctl !== exp_ctl) begin failures++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, ctl, exp_ctl); end
            checks++;
            if (fwda !== exp_a || fwdb !== exp_b) begin
                failures++; $display("FAIL rnd_fwd n=%0d got=%b/%b exp=%b/%b", n, fwda, fwdb, exp_a, exp_b);
            end
            checks++;
            if (fwda1 !== exp_a || fwdb1 !== exp_b) begin
                failures++; $display("FAIL rnd_fwd_lat1 n=%0d got=%b/%b exp=%b/%b", n, fwda1, fwdb1, exp_a, exp_b);
            end
            checks++;
            if (stall_cnt !== 16'(exp_stall)) begin
                failures++; $display("FAIL rnd_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, exp_stall);
            end
            if (!resetn) begin
                spent = 0;
                exp_stall = 0;
            end else begin
                if (!mw) begin
                    if (spent == 0 && emdu && LAT > 1) spent = 1;
                    else if (spent == LAT - 1) spent = 0;
                    else if (spent != 0) spent = spent + 1;
                end
                if (!exp_ctl[6] && exp_stall < 65535) exp_stall = exp_stall + 1;
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_mdu_memwait();
        test_branch();
        test_reset_mid_mdu();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and stall controller for the 5-stage pipeline CPU. It computes operand forwarding selects for the decode stage and detects load-use hazards. It sequences multi-cycle multiply/divide occupancy of the execute stage and freezes the back end while data memory is not ready. Its outputs drive the PC/IF-ID write enable, IF-ID flush, D/E register enable and bubble, and the E/M bubble and back-end freeze.

## Interface
- MDU_LAT, 4, total execute-stage cycles of a mul/div op; legal range 1..15
- clock  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- drs, drt  in  5 each  D-stage source register numbers
- duse_rs, duse_rt  in  1 each  D-stage instruction actually reads rs / rt
- ewreg, em2reg  in  1 each  E-stage writes register / is a load
- ern  in  5  E-stage destination register
- mwreg, mm2reg, mmem  in  1 each  M-stage writes register / is a load / accesses memory (lw or sw)
- mrn  in  5  M-stage destination register
- emdu  in  1  E-stage instruction is a mul/div
- dbranch_taken  in  1  branch/jump resolved taken in D
- dmem_ready  in  1  data memory completes the current access this cycle
- fwda, fwdb  out  2 each  operand select: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M memory data
- wpcir  out  1  PC and IF-ID write enable
- fflush  out  1  IF-ID loads a nop
- de_en  out  1  D/E register load enable
- dbubble  out  1  D/E register captures a bubble (control fields zeroed)
- em_bubble  out  1  E/M register captures a bubble
- pipe_freeze  out  1  E/M and M/W hold their contents
- mdu_done  out  1  one-cycle pulse: mul/div result valid in E this cycle
- stall_cnt  out  16  count of cycles with wpcir=0

## Operation
- State: fsm {RUN, MDU, MWAIT}, 4-bit mdu_cnt, saved-state bit ret_mdu, 16-bit stall_cnt.
- Forwarding (combinational): fwda=01 if ewreg & !em2reg & ern!=0 & ern==drs; else 10 if mwreg & !mm2reg & mrn!=0 & mrn==drs; else 11 if mwreg & mm2reg & mrn!=0 & mrn==drs; else 00. fwdb is identical on drt. E has priority over M.
- Load-use (lu): ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
- Memory wait (mw) = mmem & !dmem_ready. This has the highest priority in every state.
- mw=1 in any state: pipe_freeze=1, wpcir=0, de_en=0, dbubble=0, em_bubble=0, fflush=0. The state moves to MWAIT, ret_mdu records whether the source was MDU, and mdu_cnt is frozen.
- MWAIT with mw=0: release with normal outputs for the restored state. Next state is MDU if ret_mdu else RUN.
- RUN, emdu & MDU_LAT>1: wpcir=0, de_en=0, em_bubble=1, fflush=0. Next state MDU, mdu_cnt=MDU_LAT-1.
- RUN, lu (no emdu stall): wpcir=0, de_en=1, dbubble=1, fflush=0 (a taken branch is re-evaluated next cycle). Remain in RUN.
- RUN, no stall: wpcir=1, de_en=1, dbubble=0, em_bubble=0, fflush=dbranch_taken.
- MDU, mdu_cnt>1: hold as on entry and decrement mdu_cnt.
- MDU, mdu_cnt==1: mdu_done=1, wpcir=1, de_en=1, em_bubble=0. lu and flush are evaluated as in RUN. Next state RUN.
- stall_cnt increments when wpcir=0 and saturates at 16'hFFFF.

## Timing
- Synchronous reset: while resetn=0 at an edge, fsm=RUN, mdu_cnt=0, ret_mdu=0, stall_cnt=0.
- Outputs while resetn=0: wpcir=0, de_en=1, dbubble=1, em_bubble=1, fflush=1, pipe_freeze=0, mdu_done=0, fwda=fwdb=00.
- Reset mid-MDU or mid-MWAIT aborts the operation, with no mdu_done.
- All stall/forward outputs are Mealy: combinational from state plus current inputs, with no added latency.
- Load-use costs exactly 1 bubble cycle, because the load reaches M and forwarding 11 applies.
- A mul/div occupies E for exactly MDU_LAT cycles, plus any MWAIT cycles; mdu_done falls in the last cycle.
- MDU_LAT=1: MDU is never entered and mdu_done stays 0.

## Test plan
- Forwarding: E add writes r5, M lw writes r5, D reads rs=r5 -> fwda=01. Remove the E write -> fwda=11. With rs=r0 -> fwda=00.
- Load-use: E lw r3, D add using rt=r3 -> one cycle with wpcir=0, dbubble=1, then fwdb=11 with no stall; stall_cnt=1.
- MDU_LAT=4: emdu asserted -> wpcir=0 for 3 cycles, em_bubble=1 for 3 cycles, mdu_done pulse in the 4th cycle, stall_cnt=3.
- Memory wait during MDU: dmem_ready=0 for 2 cycles in the 2nd MDU cycle -> pipe_freeze=1 for 2 cycles, mdu_cnt frozen, mdu_done delayed by 2 cycles.
- Branch: dbranch_taken with no hazard -> fflush=1. Same cycle with lu -> fflush=0, then fflush=1 next cycle.
- Reset: resetn=0 at the 2nd MDU cycle -> next cycle fsm=RUN, stall_cnt=0, no mdu_done.
